izgara_gezgini: RTL

//  Parametrised grid walker. Takes move/turn commands over a valid/ready handshake
//  and tracks position (x,y) and heading on a 2^KW x 2^KW grid.

---
 rtl/izgara_gezgini_pkg.sv | 22 ++
 rtl/izgara_gezgini_bolge_siniflandirici.sv | 28 ++
 rtl/izgara_gezgini.sv | 115 +++++++++++
 3 files changed

// File: rtl/izgara_gezgini_pkg.sv
// Shared codes for the grid walker: heading codes, region codes and the turn helper.
package izgara_gezgini_pkg;

    // Heading codes, clockwise so a right turn is +1 mod 4
    localparam logic [1:0] YUKARI    = 2'd0;
    localparam logic [1:0] SAG       = 2'd1;
    localparam logic [1:0] ASAGI     = 2'd2;
    localparam logic [1:0] SOL       = 2'd3;

    // Region codes; also the bit index in the visited mask
    localparam logic [1:0] OTOPARK   = 2'd0;
    localparam logic [1:0] FUAYE     = 2'd1;
    localparam logic [1:0] KUTUPHANE = 2'd2;
    localparam logic [1:0] TM_217    = 2'd3;

    localparam logic [3:0] ZIYARET_BASLANGIC = 4'b1000;

    function automatic logic [1:0] yon_cevir(input logic [1:0] yon, input logic sola);
        return sola ? yon - 2'd1 : yon + 2'd1;
    endfunction

endpackage

// File: rtl/izgara_gezgini_bolge_siniflandirici.sv
// Combinational region classifier: maps a grid position to one of four region codes
// relative to the centre coordinate MERKEZ.
module bolge_siniflandirici
    import izgara_gezgini_pkg::*;
#(
    parameter int KW     = 7,
    parameter int MERKEZ = 64
) (
    input  logic [KW-1:0] x,
    input  logic [KW-1:0] y,
    output logic [1:0]    bolge
);

    localparam logic [KW-1:0] M = KW'(MERKEZ);

    // Branch order makes the x<=M and y<=M halves of the later tests implicit
    always_comb begin
        if (x > M && y > M)
            bolge = OTOPARK;
        else if (y > M)
            bolge = FUAYE;
        else if (x < M)
            bolge = KUTUPHANE;
        else
            bolge = TM_217;
    end

endmodule

// File: rtl/izgara_gezgini.sv
// Grid walker: accepts move/turn commands, tracks position/heading, classifies the
// region of the position and ends the game after HAMLE_SINIRI accepted commands.
module izgara_gezgini
    import izgara_gezgini_pkg::*;
#(
    parameter int KW           = 7,
    parameter int MERKEZ       = 64,
    parameter int HAMLE_SINIRI = 64,
    parameter int KENAR_MODU   = 0,
    localparam int CW          = $clog2(HAMLE_SINIRI + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          yeniden,
    input  logic          komut_gecerli,
    input  logic          ileri,
    input  logic          don,
    output logic          hazir,
    output logic [KW-1:0] x,
    output logic [KW-1:0] y,
    output logic [1:0]    yon,
    output logic [1:0]    bolge,
    output logic [3:0]    ziyaret,
    output logic          tum_bolgeler,
    output logic [CW-1:0] hamle_sayaci,
    output logic          sinir_carpma,
    output logic          bitti_mi
);

    localparam logic [KW-1:0] BASLANGIC = KW'(MERKEZ);
    localparam logic [KW-1:0] UST       = '1;
    localparam logic [KW-1:0] ALT       = '0;
    localparam logic [CW-1:0] SINIR     = CW'(HAMLE_SINIRI);
    localparam bit            KISITLA   = (KENAR_MODU != 0);

    logic          kabul;
    logic [KW-1:0] x_n, y_n;
    logic [1:0]    yon_n, bolge_n;
    logic [3:0]    ziyaret_n;
    logic [CW-1:0] sayac_n;
    logic          carpma_n, bitti_n;

    assign hazir        = ~bitti_mi;
    assign kabul        = komut_gecerli & ~bitti_mi;
    assign tum_bolgeler = &ziyaret;

    always_comb begin
        x_n      = x;
        y_n      = y;
        yon_n    = yon;
        sayac_n  = hamle_sayaci;
        bitti_n  = bitti_mi;
        carpma_n = 1'b0;
        if (kabul) begin
            sayac_n = hamle_sayaci + 1'b1;
            if (sayac_n == SINIR)
                bitti_n = 1'b1;
            if (!ileri) begin
                yon_n = yon_cevir(yon, don);
            end else begin
                // In clamp mode a step past an edge holds position but still counts
                case (yon)
                    YUKARI: if (KISITLA && y == UST) carpma_n = 1'b1; else y_n = y + 1'b1;
                    SAG:    if (KISITLA && x == UST) carpma_n = 1'b1; else x_n = x + 1'b1;
                    ASAGI:  if (KISITLA && y == ALT) carpma_n = 1'b1; else y_n = y - 1'b1;
                    default: if (KISITLA && x == ALT) carpma_n = 1'b1; else x_n = x - 1'b1;
                endcase
            end
        end
    end

    // Region comes from the next position so bolge/ziyaret line up with x/y
    bolge_siniflandirici #(
        .KW     (KW),
        .MERKEZ (MERKEZ)
    ) u_siniflandirici (
        .x     (x_n),
        .y     (y_n),
        .bolge (bolge_n)
    );

    assign ziyaret_n = ziyaret | (4'b0001 << bolge_n);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x            <= BASLANGIC;
            y            <= BASLANGIC;
            yon          <= YUKARI;
            bolge        <= TM_217;
            ziyaret      <= ZIYARET_BASLANGIC;
            hamle_sayaci <= '0;
            sinir_carpma <= 1'b0;
            bitti_mi     <= 1'b0;
        end else if (yeniden) begin
            x            <= BASLANGIC;
            y            <= BASLANGIC;
            yon          <= YUKARI;
            bolge        <= TM_217;
            ziyaret      <= ZIYARET_BASLANGIC;
            hamle_sayaci <= '0;
            sinir_carpma <= 1'b0;
            bitti_mi     <= 1'b0;
        end else begin
            x            <= x_n;
            y            <= y_n;
            yon          <= yon_n;
            bolge        <= bolge_n;
            ziyaret      <= ziyaret_n;
            hamle_sayaci <= sayac_n;
            sinir_carpma <= carpma_n;
            bitti_mi     <= bitti_n;
        end
    end

endmodule
